// File: rtl/approx_mac_sequencer.sv
// Dot-product sequencer around one external 8x8 approximate multiplier.
// Streams LEN operand pairs, registers each product, accumulates, and returns one sum per job.
module approx_mac_sequencer #(
  parameter int LEN   = 25,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_x,
  input  logic [7:0]       in_y,
  output logic [7:0]       mul_x,
  output logic [7:0]       mul_y,
  input  logic [15:0]      mul_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             busy
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [15:0]      r_prod_p1;
  logic             r_vld_p1;
  logic [ACC_W-1:0] r_acc_p2;
  logic             w_beat;
  logic             w_last;
  logic             w_clear;

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [15:0] p);
    return a + ACC_W'(p);
  endfunction

  assign w_beat  = in_valid & r_in_ready;
  assign w_last  = (r_cnt == CNT_W'(LEN - 1));
  assign w_clear = (r_state == S_IDLE) & start;

  // in_ready is a registered copy of "state is RUN", so the multiplier operands are gated by it
  assign mul_x     = r_in_ready ? in_x : 8'd0;
  assign mul_y     = r_in_ready ? in_y : 8'd0;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_acc   = r_out_valid ? r_acc_p2 : '0;
  assign busy      = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_prod_p1   <= '0;
      r_vld_p1    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_vld_p1 <= 1'b0;
          if (start) begin
            r_state    <= S_RUN;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          // stage p0 -> p1: capture multiplier product on each accepted beat
          r_vld_p1 <= w_beat;
          if (w_beat) begin
            r_prod_p1 <= mul_z;
            r_cnt     <= r_cnt + 1'b1;
            if (w_last) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          r_vld_p1    <= 1'b0;
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
        end
        S_DONE: begin
          r_vld_p1 <= 1'b0;
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_vld_p1    <= 1'b0;
        end
      endcase
    end
  end

  // stage p1 -> p2: accumulate every registered product, whatever the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_p2 <= '0;
    end else if (w_clear) begin
      r_acc_p2 <= '0;
    end else if (r_vld_p1) begin
      r_acc_p2 <= acc_add(r_acc_p2, r_prod_p1);
    end
  end

endmodule

// File: tb/tb_approx_mac_sequencer.sv
// Randomized bench for approx_mac_sequencer: three instances (LEN=4, 25, 1) with an exact multiplier stub,
// checked against a sum-of-products reference model.
module tb_approx_mac_sequencer;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic [7:0]       in_x = 8'd0;
  logic [7:0]       in_y = 8'd0;
  logic [2:0]       st = 3'b000;
  logic [2:0]       ir, ov, bz;
  logic [2:0][7:0]  mx, my;
  logic [2:0][23:0] oa;
  logic [15:0]      mz0, mz1, mz2;

  int n_checks = 0;
  int n_pass   = 0;
  int px[256];
  int py[256];
  int lens[3] = '{4, 25, 1};

  always #5 clk = ~clk;

  assign mz0 = 16'(mx[0]) * 16'(my[0]);
  assign mz1 = 16'(mx[1]) * 16'(my[1]);
  assign mz2 = 16'(mx[2]) * 16'(my[2]);

  approx_mac_sequencer #(.LEN(4), .ACC_W(24)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .in_valid(in_valid), .in_ready(ir[0]),
    .in_x(in_x), .in_y(in_y), .mul_x(mx[0]), .mul_y(my[0]), .mul_z(mz0),
    .out_valid(ov[0]), .out_ready(out_ready), .out_acc(oa[0]), .busy(bz[0]));

  approx_mac_sequencer #(.LEN(25), .ACC_W(24)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .in_valid(in_valid), .in_ready(ir[1]),
    .in_x(in_x), .in_y(in_y), .mul_x(mx[1]), .mul_y(my[1]), .mul_z(mz1),
    .out_valid(ov[1]), .out_ready(out_ready), .out_acc(oa[1]), .busy(bz[1]));

  approx_mac_sequencer #(.LEN(1), .ACC_W(24)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .in_valid(in_valid), .in_ready(ir[2]),
    .in_x(in_x), .in_y(in_y), .mul_x(mx[2]), .mul_y(my[2]), .mul_z(mz2),
    .out_valid(ov[2]), .out_ready(out_ready), .out_acc(oa[2]), .busy(bz[2]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_zero(input int k, input string tag);
    check_val({tag, "_in_ready"},  32'(ir[k]), 0);
    check_val({tag, "_out_valid"}, 32'(ov[k]), 0);
    check_val({tag, "_out_acc"},   32'(oa[k]), 0);
    check_val({tag, "_busy"},      32'(bz[k]), 0);
    check_val({tag, "_mul_x"},     32'(mx[k]), 0);
    check_val({tag, "_mul_y"},     32'(my[k]), 0);
  endtask

  // Runs one job on instance k using px/py; called and returning at a falling edge.
  task automatic run_job(input int k, input int gap_mode, input int hold, input bit poke,
                         input int abort_at, input int exp_val);
    int len = lens[k];
    int beats = 0;
    int cyc = 0;
    int sum = 0;
    bit v;
    in_x = 8'($urandom_range(1, 255));
    in_y = 8'($urandom_range(1, 255));
    st[k] = 1'b1;
    #1;
    check_val("idle_mul_x", 32'(mx[k]), 0);
    check_val("idle_mul_y", 32'(my[k]), 0);
    @(negedge clk);
    st[k] = 1'b0;
    while (beats < len && cyc < 4 * len + 20) begin
      case (gap_mode)
        1:       v = (cyc % 2 == 0);
        2:       v = ($urandom_range(0, 3) != 0);
        default: v = 1'b1;
      endcase
      in_valid = v;
      in_x = v ? 8'(px[beats]) : 8'($urandom);
      in_y = v ? 8'(py[beats]) : 8'($urandom);
      st[k] = poke && (cyc == 3);
      #1;
      check_val("run_in_ready", 32'(ir[k]), 1);
      check_val("run_mul_x", 32'(mx[k]), 32'(in_x));
      check_val("run_mul_y", 32'(my[k]), 32'(in_y));
      @(posedge clk);
      if (v) begin
        sum += px[beats] * py[beats];
        beats++;
      end
      if (abort_at > 0 && beats == abort_at) begin
        #2 rst = 1'b1;
        #1 check_zero(k, "abort");
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        st[k] = 1'b0;
        #1 check_val("abort_idle_busy", 32'(bz[k]), 0);
        return;
      end
      @(negedge clk);
      cyc++;
    end
    st[k] = 1'b0;
    if (beats < len) begin
      check_val("beat_timeout", 32'(beats), 32'(len));
      return;
    end
    in_valid = 1'b0;
    in_x = 8'($urandom_range(1, 255));
    in_y = 8'($urandom_range(1, 255));
    out_ready = (hold == 0);
    #1;
    check_val("drain_in_ready", 32'(ir[k]), 0);
    check_val("drain_out_valid", 32'(ov[k]), 0);
    check_val("drain_mul_x", 32'(mx[k]), 0);
    check_val("drain_busy", 32'(bz[k]), 1);
    @(negedge clk);
    check_val("done_out_valid", 32'(ov[k]), 1);
    check_val("done_out_acc", 32'(oa[k]), 32'(sum) & 32'hFF_FFFF);
    check_val("done_mul_y", 32'(my[k]), 0);
    if (exp_val >= 0) check_val("done_spec_acc", 32'(oa[k]), 32'(exp_val));
    for (int h = 1; h < hold; h++) begin
      st[k] = poke && (h == 2);
      @(negedge clk);
      check_val("hold_out_valid", 32'(ov[k]), 1);
      check_val("hold_out_acc", 32'(oa[k]), 32'(sum) & 32'hFF_FFFF);
    end
    st[k] = poke;
    out_ready = 1'b1;
    @(negedge clk);
    st[k] = 1'b0;
    check_val("post_out_valid", 32'(ov[k]), 0);
    check_val("post_busy", 32'(bz[k]), 0);
    check_val("post_out_acc", 32'(oa[k]), 0);
    @(negedge clk);
    check_val("idle_busy", 32'(bz[k]), 0);
    check_val("idle_in_ready", 32'(ir[k]), 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    in_x = 8'hA5;
    in_y = 8'h5A;
    #3;
    for (int k = 0; k < 3; k++) check_zero(k, "reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    px[0] = 1;   py[0] = 1;
    px[1] = 2;   py[1] = 3;
    px[2] = 255; py[2] = 255;
    px[3] = 10;  py[3] = 10;
    run_job(0, 0, 0, 1'b0, 0, 65132);

    for (int i = 0; i < 25; i++) begin px[i] = 255; py[i] = 255; end
    run_job(1, 1, 5, 1'b1, 0, 1625625);

    for (int i = 0; i < 25; i++) begin px[i] = int'($urandom_range(0, 255)); py[i] = int'($urandom_range(0, 255)); end
    run_job(1, 2, 0, 1'b0, 10, -1);
    for (int i = 0; i < 25; i++) begin px[i] = 2; py[i] = 2; end
    run_job(1, 0, 0, 1'b0, 0, 100);

    px[0] = 7; py[0] = 9;
    run_job(2, 0, 2, 1'b1, 0, 63);

    repeat (4) begin
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 25; i++) begin
          px[i] = int'($urandom_range(0, 255));
          py[i] = int'($urandom_range(0, 255));
        end
        run_job(k, 2, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 0, -1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
